// File: rtl/mem_access_unit_if.sv
// Request/response handshake and word-wide data-memory port
// shared by the execute stage, mem_access_unit and data memory.
interface mem_access_unit_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_write;
    logic [31:0]   mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed,
        input  req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_write
    );

    modport master (
        output req_valid, req_write, req_size, req_signed,
        output req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_write
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator: byte/half/word accesses onto a word-only
// data memory, sub-word stores done as read-modify-write.
module mem_access_unit #(
    parameter int AW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t        r_state, w_state_nx;
    logic [2:0]    r_cnt, w_cnt_nx;
    logic          r_write, w_write_nx;
    logic [1:0]    r_size, w_size_nx;
    logic          r_signed, w_signed_nx;
    logic [1:0]    r_lo, w_lo_nx;
    logic [15:0]   r_wdata, w_wdata_nx;
    logic [AW-3:0] r_mem_addr, w_mem_addr_nx;
    logic [31:0]   r_mem_wdata, w_mem_wdata_nx;
    logic          r_mem_write, w_mem_write_nx;
    logic          r_resp_valid, w_resp_valid_nx;
    logic [31:0]   r_resp_rdata, w_resp_rdata_nx;
    logic          r_resp_err, w_resp_err_nx;
    logic          w_accept;
    logic          w_misal;

    function automatic logic [31:0] f_merge(
        input logic [31:0] word,
        input logic [1:0]  sz,
        input logic [1:0]  lo,
        input logic [15:0] d
    );
        logic [31:0] m;
        m = word;
        if (sz == 2'd0)
            m[{lo, 3'b000} +: 8] = d[7:0];
        else
            m[{lo[1], 4'b0000} +: 16] = d;
        return m;
    endfunction

    function automatic logic [31:0] f_extract(
        input logic [31:0] word,
        input logic [1:0]  sz,
        input logic [1:0]  lo,
        input logic        sg
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        unique case (sz)
            2'd0:    r = {{24{sg & b[7]}}, b};
            2'd1:    r = {{16{sg & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign w_accept = bus.req_valid && (r_state == S_IDLE);

    assign w_misal = (bus.req_size == 2'd3)
                  || (bus.req_size == 2'd1 && bus.req_addr[0])
                  || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0);

    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_write_nx      = r_write;
        w_size_nx       = r_size;
        w_signed_nx     = r_signed;
        w_lo_nx         = r_lo;
        w_wdata_nx      = r_wdata;
        w_mem_addr_nx   = r_mem_addr;
        w_mem_wdata_nx  = r_mem_wdata;
        w_mem_write_nx  = 1'b0;
        w_resp_valid_nx = 1'b0;
        w_resp_rdata_nx = r_resp_rdata;
        w_resp_err_nx   = r_resp_err;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_write_nx  = bus.req_write;
                    w_size_nx   = bus.req_size;
                    w_signed_nx = bus.req_signed;
                    w_lo_nx     = bus.req_addr[1:0];
                    w_wdata_nx  = bus.req_wdata[15:0];
                    if (w_misal) begin
                        w_state_nx      = S_RESP;
                        w_resp_valid_nx = 1'b1;
                        w_resp_rdata_nx = '0;
                        w_resp_err_nx   = 1'b1;
                    end else if (bus.req_write && bus.req_size == 2'd2) begin
                        w_state_nx     = S_WRITE;
                        w_mem_addr_nx  = bus.req_addr[AW-1:2];
                        w_mem_wdata_nx = bus.req_wdata;
                        w_mem_write_nx = 1'b1;
                    end else begin
                        w_state_nx    = S_READ;
                        w_mem_addr_nx = bus.req_addr[AW-1:2];
                        w_cnt_nx      = 3'd0;
                    end
                end
            end
            S_READ: begin
                // mem_rdata is sampled on the edge closing the last read cycle
                if (r_cnt == LAT) begin
                    if (r_write) begin
                        w_state_nx     = S_WRITE;
                        w_mem_write_nx = 1'b1;
                        w_mem_wdata_nx = f_merge(bus.mem_rdata, r_size,
                                                 r_lo, r_wdata);
                    end else begin
                        w_state_nx      = S_RESP;
                        w_resp_valid_nx = 1'b1;
                        w_resp_err_nx   = 1'b0;
                        w_resp_rdata_nx = f_extract(bus.mem_rdata, r_size,
                                                    r_lo, r_signed);
                    end
                end else begin
                    w_cnt_nx = r_cnt + 3'd1;
                end
            end
            S_WRITE: begin
                w_state_nx      = S_RESP;
                w_resp_valid_nx = 1'b1;
                w_resp_rdata_nx = '0;
                w_resp_err_nx   = 1'b0;
            end
            S_RESP: begin
                w_state_nx      = S_IDLE;
                w_resp_rdata_nx = '0;
                w_resp_err_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_lo         <= '0;
            r_wdata      <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_write  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_write      <= w_write_nx;
            r_size       <= w_size_nx;
            r_signed     <= w_signed_nx;
            r_lo         <= w_lo_nx;
            r_wdata      <= w_wdata_nx;
            r_mem_addr   <= w_mem_addr_nx;
            r_mem_wdata  <= w_mem_wdata_nx;
            r_mem_write  <= w_mem_write_nx;
            r_resp_valid <= w_resp_valid_nx;
            r_resp_rdata <= w_resp_rdata_nx;
            r_resp_err   <= w_resp_err_nx;
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_write  = r_mem_write;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-level reference model
// predicts responses and memory writes, a monitor checks the DUT.
module tb_mem_access_unit;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if #(.AW(32)) bus ();

    mem_access_unit #(.AW(32), .MEM_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    resp_t rq[$];
    wr_t   wq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic [5:0]  apipe   [LAT];

    // data memory: registered read pipeline of LAT stages
    always @(posedge clk) begin
        if (bus.mem_write === 1'b1)
            mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        apipe[0] <= bus.mem_addr[5:0];
        for (int i = 1; i < LAT; i++)
            apipe[i] <= apipe[i-1];
    end
    assign bus.mem_rdata = mem[apipe[LAT-1]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void model(input logic w, input logic [1:0] sz,
                                  input logic sg, input logic [31:0] a,
                                  input logic [31:0] d, input int e);
        int          nb;
        int          sh;
        int          wi;
        int          lat;
        logic [31:0] mask;
        logic [31:0] v;
        resp_t       r;
        wr_t         x;
        nb = 1 << sz;
        sh = 8 * int'(a % 4);
        wi = int'(a / 4) % 64;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        if (sz == 2'd3 || (a % nb) != 0) begin
            r = '{data: 32'd0, err: 1'b1, cyc: e};
            rq.push_back(r);
        end else if (w) begin
            v = (ref_mem[wi] & ~(mask << sh)) | ((d & mask) << sh);
            ref_mem[wi] = v;
            lat = (nb == 4) ? 0 : 1 + LAT;
            x = '{addr: 30'(a / 4), data: v, cyc: e + lat};
            wq.push_back(x);
            r = '{data: 32'd0, err: 1'b0, cyc: e + lat + 1};
            rq.push_back(r);
        end else begin
            v = (ref_mem[wi] >> sh) & mask;
            if (sg && v[8*nb-1]) v = v | ~mask;
            r = '{data: v, err: 1'b0, cyc: e + 1 + LAT};
            rq.push_back(r);
        end
    endfunction

    // monitor
    initial forever begin
        resp_t r;
        wr_t   x;
        @(negedge clk);
        if (bus.mem_write === 1'b1) begin
            if (wq.size() == 0) begin
                chk("spurious_write", {31'd0, bus.mem_write}, 32'd0);
            end else begin
                x = wq.pop_front();
                chk("wr_addr", {2'b00, bus.mem_addr}, {2'b00, x.addr});
                chk("wr_data", bus.mem_wdata, x.data);
                chk("wr_cycle", cyc, x.cyc);
            end
        end
        if (bus.resp_valid === 1'b1) begin
            if (rq.size() == 0) begin
                chk("spurious_resp", {31'd0, bus.resp_valid}, 32'd0);
            end else begin
                r = rq.pop_front();
                chk("resp_rdata", bus.resp_rdata, r.data);
                chk("resp_err", {31'd0, bus.resp_err}, {31'd0, r.err});
                chk("resp_cycle", cyc, r.cyc);
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] d, input bit track);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            chk("ready_timeout", {31'd0, bus.req_ready}, 32'd1);
            return;
        end
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        if (track) model(w, sz, sg, a, d, cyc + 1);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", rq.size() + wq.size(), 32'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        chk({tag, "_maddr"}, {2'b00, bus.mem_addr}, 32'd0);
        chk({tag, "_mwdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_mwrite"}, {31'd0, bus.mem_write}, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, bus.resp_valid}, 32'd0);
        chk({tag, "_rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, "_rerr"}, {31'd0, bus.resp_err}, 32'd0);
    endtask

    initial begin
        int nmis;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 64; i++)
            issue(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 1'b1);
        drain();

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 1'b1);
        issue(1'b1, 2'd0, 1'b0, 32'h22, 32'h5555_55AA, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 32'h30, 32'h0080_FF7F, 1'b1);
        issue(1'b0, 2'd0, 1'b1, 32'h31, 32'h0, 1'b1);
        issue(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 1'b1);
        issue(1'b0, 2'd0, 1'b1, 32'h30, 32'h0, 1'b1);
        issue(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 1'b1);
        issue(1'b1, 2'd1, 1'b0, 32'h36, 32'hABCD_8001, 1'b1);
        issue(1'b0, 2'd1, 1'b0, 32'h41, 32'h0, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 32'h42, 32'h1234_5678, 1'b1);
        issue(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 1'b1);
        issue(1'b1, 2'd3, 1'b0, 32'h44, 32'h0, 1'b1);
        drain();

        // abort a byte RMW during its read phase
        issue(1'b1, 2'd0, 1'b0, 32'h51, 32'h0000_005A, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_rst");
        repeat (4) @(negedge clk);
        chk("rmw_abort_mem", mem[20], ref_mem[20]);
        issue(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 1'b1);
        drain();

        repeat (300) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                  32'($urandom_range(0, 255)), $urandom, 1'b1);
        end
        drain();

        nmis = 0;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== ref_mem[i]) nmis++;
        chk("final_mem_words", nmis, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
